// File: rtl/csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module  : csr_counter_bank
// Desc    : Bank of 64-bit performance counters (cycle/time/instret/hpm) with
//           user read-only and machine read/write CSR aliases.
// Revision: 1.0
// ============================================================================
module csr_counter_bank #(
  parameter int XLEN      = 32,
  parameter int NUM_HPM   = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         priv_mode,
  input  logic               req_valid,
  input  logic [11:0]        req_addr,
  input  logic               req_write,
  input  logic [1:0]         req_func,
  input  logic [XLEN-1:0]    req_wdata,
  input  logic               instr_retired,
  input  logic               time_tick,
  input  logic [NUM_HPM-1:0] hpm_event,
  output logic               rsp_valid,
  output logic [XLEN-1:0]    rsp_rdata,
  output logic               rsp_illegal
);

  localparam int              NCNT               = NUM_HPM + 3;
  localparam logic [XLEN-1:0] EN_MASK            = XLEN'((64'd1 << NCNT) - 64'd1);
  localparam logic [XLEN-1:0] INH_MASK           = EN_MASK & ~XLEN'(2);
  localparam logic [11:0]     ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0]     ADDR_MCOUNTEREN    = 12'h306;
  localparam logic [1:0]      FUNC_RS            = 2'b10;
  localparam logic [1:0]      FUNC_RC            = 2'b11;
  localparam logic [1:0]      PRIV_M             = 2'b11;

  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [NCNT];
  logic [XLEN-1:0]      inhibit_q, inhibit_d;
  logic [XLEN-1:0]      enable_q, enable_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_illegal_q, rsp_illegal_d;
  logic [XLEN-1:0]      rsp_rdata_q, rsp_rdata_d;

  logic [NCNT-1:0]      inc;
  logic [4:0]           idx;
  logic                 hi_half, is_user, is_mach, is_inh, is_en, is_m, idx_ok;
  logic                 illegal, do_write;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic [XLEN-1:0]      old_val, new_val;

  generate
    if (NUM_HPM > 0) begin : g_hpm
      assign inc = {hpm_event, instr_retired, time_tick, 1'b1};
    end else begin : g_no_hpm
      assign inc = {instr_retired, time_tick, 1'b1};
    end
  endgenerate

  always_comb begin
    idx     = req_addr[4:0];
    hi_half = req_addr[7];
    is_user = (req_addr[11:8] == 4'hC) && (req_addr[6:5] == 2'b00);
    is_mach = (req_addr[11:8] == 4'hB) && (req_addr[6:5] == 2'b00);
    is_inh  = (req_addr == ADDR_MCOUNTINHIBIT);
    is_en   = (req_addr == ADDR_MCOUNTEREN);
    is_m    = (priv_mode == PRIV_M);
    idx_ok  = (int'(idx) < NCNT);

    sel_cnt = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (int'(idx) == i) sel_cnt = cnt_q[i];
    end

    if (is_user)              illegal = !idx_ok || req_write || (!is_m && !enable_q[idx]);
    else if (is_mach)         illegal = !idx_ok || (idx == 5'd1) || !is_m;
    else if (is_inh || is_en) illegal = !is_m;
    else                      illegal = 1'b1;

    old_val = '0;
    if (is_user || is_mach) old_val = hi_half ? sel_cnt[CNT_WIDTH-1:XLEN] : sel_cnt[XLEN-1:0];
    else if (is_inh)        old_val = inhibit_q;
    else if (is_en)         old_val = enable_q;

    case (req_func)
      FUNC_RS: new_val = old_val | req_wdata;
      FUNC_RC: new_val = old_val & ~req_wdata;
      default: new_val = req_wdata;
    endcase

    // func 2'b00 is not a write encoding, so it never modifies state
    do_write = req_valid && req_write && !illegal && (req_func != 2'b00);

    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!inhibit_q[i]) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(inc[i]);
      // a written counter drops its increment so nothing carries into the other half
      if (do_write && is_mach && (int'(idx) == i)) begin
        cnt_d[i] = cnt_q[i];
        if (hi_half) cnt_d[i][CNT_WIDTH-1:XLEN] = new_val;
        else         cnt_d[i][XLEN-1:0]         = new_val;
      end
    end

    inhibit_d = (do_write && is_inh) ? (new_val & INH_MASK) : inhibit_q;
    enable_d  = (do_write && is_en)  ? (new_val & EN_MASK)  : enable_q;

    rsp_valid_d   = req_valid;
    rsp_illegal_d = req_valid && illegal;
    rsp_rdata_d   = (req_valid && !illegal) ? old_val : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      inhibit_q     <= '0;
      enable_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      inhibit_q     <= inhibit_d;
      enable_q      <= enable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
`default_nettype wire
